// File: rtl/spi_regs_pkg.sv
// spi_regs_pkg: shared address width, default bank size and arbiter state encoding
package spi_regs_pkg;
    localparam int ADDR_W = 7;
    localparam int NUM_REGS_DEFAULT = 16;
    typedef enum logic [1:0] {IDLE = 2'd0, SPI_WR = 2'd1, LOC_ACC = 2'd2} arb_state_e;
    function automatic logic addr_ok(input logic [ADDR_W-1:0] addr, input int num_regs);
        return int'(addr) < num_regs;
    endfunction
endpackage

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: register bank with one write port and two registered read ports
module spi_reg_bank
    import spi_regs_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = NUM_REGS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic              rb_en,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data
);
    localparam int IDX_W = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
    logic [DATA_W-1:0] bank_q [NUM_REGS];
    logic [DATA_W-1:0] bank_d [NUM_REGS];
    logic [DATA_W-1:0] ra_data_q, ra_data_d, rb_data_q, rb_data_d;
    logic [IDX_W-1:0]  widx, raidx, rbidx;
    // Reads sample the pre-write contents, so a same-cycle write shows up one cycle later
    always_comb begin
        widx = waddr[IDX_W-1:0];
        raidx = ra_addr[IDX_W-1:0];
        rbidx = rb_addr[IDX_W-1:0];
        bank_d = bank_q;
        if (we && addr_ok(waddr, NUM_REGS))
            bank_d[widx] = wdata;
        ra_data_d = addr_ok(ra_addr, NUM_REGS) ? bank_q[raidx] : '0;
        rb_data_d = !rb_en ? rb_data_q : addr_ok(rb_addr, NUM_REGS) ? bank_q[rbidx] : '0;
        ra_data = ra_data_q;
        rb_data = rb_data_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q    <= '{default: '0};
            ra_data_q <= '0;
            rb_data_q <= '0;
        end else begin
            bank_q    <= bank_d;
            ra_data_q <= ra_data_d;
            rb_data_q <= rb_data_d;
        end
    end
endmodule

// File: rtl/spi_reg_arbiter.sv
// spi_reg_arbiter: arbitrates SPI and local fabric access to a shared register bank
module spi_reg_arbiter
    import spi_regs_pkg::*;
#(
    parameter int DATA_REGISTER_LENGTH = 64,
    parameter int NUM_REGS             = NUM_REGS_DEFAULT
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ADDR_W-1:0]               spi_addr,
    input  logic [DATA_REGISTER_LENGTH-1:0] spi_wdata,
    input  logic                            spi_wr_en,
    output logic [DATA_REGISTER_LENGTH-1:0] spi_rdata,
    input  logic                            loc_req,
    input  logic                            loc_we,
    input  logic [ADDR_W-1:0]               loc_addr,
    input  logic [DATA_REGISTER_LENGTH-1:0] loc_wdata,
    output logic                            loc_gnt,
    output logic [DATA_REGISTER_LENGTH-1:0] loc_rdata,
    output logic                            loc_rvalid,
    output logic                            err_addr,
    output logic                            err_ovf
);
    arb_state_e                      state_q, state_d;
    logic                            pend_v_q, pend_v_d;
    logic [ADDR_W-1:0]               pend_addr_q, pend_addr_d;
    logic [DATA_REGISTER_LENGTH-1:0] pend_data_q, pend_data_d;
    logic                            loc_pri_q, loc_pri_d;
    logic                            loc_rvalid_q, loc_rvalid_d;
    logic                            err_addr_q, err_addr_d;
    logic                            err_ovf_q, err_ovf_d;
    logic                            drain, capture, bank_we, rd_en;
    logic [ADDR_W-1:0]               bank_waddr;
    logic [DATA_REGISTER_LENGTH-1:0] bank_wdata;
    always_comb begin
        drain = state_q == SPI_WR;
        loc_gnt = state_q == LOC_ACC && loc_req;
        // A local request that waited through an SPI write wins the next arbitration
        state_d = state_q != IDLE ? IDLE :
                  pend_v_q && !(loc_pri_q && loc_req) ? SPI_WR :
                  loc_req ? LOC_ACC : IDLE;
        loc_pri_d = drain ? loc_req : state_q == LOC_ACC ? 1'b0 : loc_pri_q;
        capture = spi_wr_en && (!pend_v_q || drain);
        pend_v_d = spi_wr_en ? 1'b1 : drain ? 1'b0 : pend_v_q;
        pend_addr_d = capture ? spi_addr : pend_addr_q;
        pend_data_d = capture ? spi_wdata : pend_data_q;
        bank_we = drain ? addr_ok(pend_addr_q, NUM_REGS) :
                  loc_gnt && loc_we && addr_ok(loc_addr, NUM_REGS);
        bank_waddr = drain ? pend_addr_q : loc_addr;
        bank_wdata = drain ? pend_data_q : loc_wdata;
        rd_en = loc_gnt && !loc_we;
        loc_rvalid_d = rd_en;
        err_addr_d = err_addr_q || (drain && !addr_ok(pend_addr_q, NUM_REGS)) ||
                     (loc_gnt && !addr_ok(loc_addr, NUM_REGS));
        err_ovf_d = err_ovf_q || (spi_wr_en && pend_v_q && !drain);
        loc_rvalid = loc_rvalid_q;
        err_addr = err_addr_q;
        err_ovf = err_ovf_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pend_v_q     <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            loc_pri_q    <= 1'b0;
            loc_rvalid_q <= 1'b0;
            err_addr_q   <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_v_q     <= pend_v_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            loc_pri_q    <= loc_pri_d;
            loc_rvalid_q <= loc_rvalid_d;
            err_addr_q   <= err_addr_d;
            err_ovf_q    <= err_ovf_d;
        end
    end
    spi_reg_bank #(
        .DATA_W   (DATA_REGISTER_LENGTH),
        .NUM_REGS (NUM_REGS)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .we      (bank_we),
        .waddr   (bank_waddr),
        .wdata   (bank_wdata),
        .ra_addr (spi_addr),
        .ra_data (spi_rdata),
        .rb_en   (rd_en),
        .rb_addr (loc_addr),
        .rb_data (loc_rdata)
    );
endmodule

// File: tb/tb_spi_reg_arbiter.sv
// tb_spi_reg_arbiter: directed plus randomized checks of spi_reg_arbiter against an array model
module tb_spi_reg_arbiter;
    localparam int W = 64;
    localparam int N = 16;
    logic         clk = 1'b0;
    logic         rst;
    logic [6:0]   spi_addr;
    logic [W-1:0] spi_wdata;
    logic         spi_wr_en;
    logic [W-1:0] spi_rdata;
    logic         loc_req;
    logic         loc_we;
    logic [6:0]   loc_addr;
    logic [W-1:0] loc_wdata;
    logic         loc_gnt;
    logic [W-1:0] loc_rdata;
    logic         loc_rvalid;
    logic         err_addr;
    logic         err_ovf;
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] model [N];
    logic [W-1:0] hist [$];
    logic [W-1:0] rd, d, va, vb;
    logic         pg, ok;
    int           grants, n;
    logic [6:0]   a;

    always #5 clk = ~clk;

    spi_reg_arbiter #(.DATA_REGISTER_LENGTH(W), .NUM_REGS(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .spi_addr   (spi_addr),
        .spi_wdata  (spi_wdata),
        .spi_wr_en  (spi_wr_en),
        .spi_rdata  (spi_rdata),
        .loc_req    (loc_req),
        .loc_we     (loc_we),
        .loc_addr   (loc_addr),
        .loc_wdata  (loc_wdata),
        .loc_gnt    (loc_gnt),
        .loc_rdata  (loc_rdata),
        .loc_rvalid (loc_rvalid),
        .err_addr   (err_addr),
        .err_ovf    (err_ovf)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic spi_wr(input logic [6:0] addr, input logic [W-1:0] data);
        spi_addr = addr;
        spi_wdata = data;
        spi_wr_en = 1'b1;
        tick();
        spi_wr_en = 1'b0;
    endtask

    task automatic wait_spi(input logic [6:0] addr, input logic [W-1:0] exp, input string tag);
        int k = 0;
        spi_addr = addr;
        tick();
        while (spi_rdata !== exp && k < 8) begin
            tick();
            k++;
        end
        chk(tag, spi_rdata, exp);
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < N; i++) begin
            spi_addr = 7'(i);
            tick();
            chk(tag, spi_rdata, model[i]);
        end
    endtask

    task automatic loc_op(input logic we, input logic [6:0] addr, input logic [W-1:0] data,
                          output logic [W-1:0] rdata);
        int k = 0;
        loc_req = 1'b1;
        loc_we = we;
        loc_addr = addr;
        loc_wdata = data;
        while (!loc_gnt && k < 10) begin
            tick();
            k++;
        end
        chk("loc_gnt_seen", loc_gnt, 1);
        tick();
        chk("loc_gnt_one_cycle", loc_gnt, 0);
        chk("loc_rvalid", loc_rvalid, !we);
        rdata = loc_rdata;
        loc_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        spi_addr = 7'd3;
        spi_wdata = '0;
        spi_wr_en = 1'b0;
        loc_req = 1'b0;
        loc_we = 1'b0;
        loc_addr = '0;
        loc_wdata = '0;
        for (int i = 0; i < N; i++) model[i] = '0;
        tick();
        tick();
        chk("rst_spi_rdata", spi_rdata, 0);
        chk("rst_loc_rdata", loc_rdata, 0);
        chk("rst_loc_gnt", loc_gnt, 0);
        chk("rst_loc_rvalid", loc_rvalid, 0);
        chk("rst_err_addr", err_addr, 0);
        chk("rst_err_ovf", err_ovf, 0);
        rst = 1'b0;
        tick();
        chk("spi_rdata_addr3", spi_rdata, 0);
        read_all("rst_bank_zero");

        d = 64'hDEAD_BEEF_0000_0001;
        spi_wr(7'd5, d);
        n = 0;
        while (spi_rdata !== d && n < 8) begin
            tick();
            n++;
        end
        chk("spi_wr_visible", spi_rdata, d);
        chk("spi_wr_latency", n <= 3, 1);
        model[5] = d;

        hist.push_back(model[5]);
        pg = 1'b0;
        grants = 0;
        loc_we = 1'b0;
        loc_addr = 7'd5;
        loc_req = 1'b1;
        spi_addr = 7'd5;
        for (int c = 0; c < 48; c++) begin
            if (c % 4 == 0) begin
                d = {$urandom, $urandom};
                spi_wdata = d;
                spi_wr_en = 1'b1;
                hist.push_back(d);
            end else spi_wr_en = 1'b0;
            tick();
            chk("rvalid_after_gnt", loc_rvalid, pg);
            if (pg) begin
                ok = 1'b0;
                for (int k = 0; k < 3; k++)
                    if (hist.size() > k && loc_rdata === hist[hist.size()-1-k]) ok = 1'b1;
                chk("loc_rd_value", ok, 1);
            end
            if (loc_gnt) grants++;
            pg = loc_gnt;
        end
        spi_wr_en = 1'b0;
        if (loc_gnt) tick();
        loc_req = 1'b0;
        chk("grants_between_spi", grants >= 10, 1);
        chk("no_ovf_interleave", err_ovf, 0);
        model[5] = hist[hist.size()-1];
        wait_spi(7'd5, model[5], "spi_last_write");

        va = {$urandom, $urandom} | 64'h1;
        vb = {$urandom, $urandom} | 64'h2;
        loc_req = 1'b1;
        loc_we = 1'b0;
        loc_addr = 7'd1;
        n = 0;
        while (!loc_gnt && n < 10) begin
            tick();
            n++;
        end
        chk("ovf_gnt_seen", loc_gnt, 1);
        spi_addr = 7'd7;
        spi_wdata = va;
        spi_wr_en = 1'b1;
        tick();
        loc_req = 1'b0;
        chk("ovf_rvalid", loc_rvalid, 1);
        chk("ovf_rdata", loc_rdata, model[1]);
        spi_wdata = vb;
        tick();
        spi_wr_en = 1'b0;
        chk("err_ovf_set", err_ovf, 1);
        model[7] = va;
        wait_spi(7'd7, va, "ovf_first_kept");
        for (int k = 0; k < 4; k++) tick();
        chk("ovf_second_dropped", spi_rdata, va);

        loc_op(1'b1, 7'd20, {$urandom, $urandom}, rd);
        chk("err_addr_set", err_addr, 1);
        loc_op(1'b0, 7'd20, '0, rd);
        chk("bad_loc_read_zero", rd, 0);
        spi_addr = 7'd20;
        tick();
        chk("bad_spi_read_zero", spi_rdata, 0);
        spi_wr(7'd100, {$urandom, $urandom});
        for (int k = 0; k < 3; k++) tick();
        read_all("bad_addr_no_change");

        for (int it = 0; it < 150; it++) begin
            d = {$urandom, $urandom};
            case ($urandom_range(0, 2))
                0: begin
                    a = 7'(2 * $urandom_range(0, N/2 - 1));
                    spi_wr(a, d);
                    model[a] = d;
                    for (int k = 0; k < 3; k++) tick();
                end
                1: begin
                    a = 7'(2 * $urandom_range(0, N/2 - 1) + 1);
                    loc_op(1'b1, a, d, rd);
                    model[a] = d;
                end
                default: begin
                    a = 7'(2 * $urandom_range(0, N/2 - 1) + 1);
                    loc_op(1'b0, a, '0, rd);
                    chk("rand_loc_read", rd, model[a]);
                end
            endcase
        end
        read_all("rand_spi_final");
        for (int i = 0; i < N; i++) begin
            loc_op(1'b0, 7'(i), '0, rd);
            chk("rand_loc_final", rd, model[i]);
        end
        chk("err_addr_sticky", err_addr, 1);
        chk("err_ovf_sticky", err_ovf, 1);

        d = {$urandom, $urandom} | 64'h1;
        spi_wr(7'd6, d);
        model[6] = d;
        wait_spi(7'd6, d, "pre_reset_value");
        spi_wr(7'd2, {$urandom, $urandom} | 64'h4);
        spi_addr = 7'd6;
        tick();
        #2;
        loc_req = 1'b1;
        rst = 1'b1;
        #1;
        chk("async_rst_spi_rdata", spi_rdata, 0);
        chk("async_rst_loc_rdata", loc_rdata, 0);
        chk("async_rst_loc_gnt", loc_gnt, 0);
        chk("async_rst_loc_rvalid", loc_rvalid, 0);
        chk("async_rst_err_addr", err_addr, 0);
        chk("async_rst_err_ovf", err_ovf, 0);
        tick();
        tick();
        chk("rst_hold_loc_gnt", loc_gnt, 0);
        loc_req = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < N; i++) model[i] = '0;
        for (int k = 0; k < 3; k++) tick();
        read_all("post_rst_bank_zero");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_reg_arbiter.md
SPI_REG_ARBITER -- requirements
Module: spi_reg_arbiter

Interface
REQ-001 SHALL have parameter DATA_REGISTER_LENGTH, default 64, width of each register and both data ports.
REQ-002 SHALL have parameter NUM_REGS, default 16, number of implemented registers (addresses 0..NUM_REGS-1, NUM_REGS<=127).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port spi_addr  input  7  register address from the SPI slave.
REQ-006 SHALL have port spi_wdata  input  DATA_REGISTER_LENGTH  write data from the SPI slave.
REQ-007 SHALL have port spi_wr_en  input  1  one-cycle write strobe from the SPI slave.
REQ-008 SHALL have port spi_rdata  output  DATA_REGISTER_LENGTH  read data to the SPI slave.
REQ-009 SHALL have port loc_req  input  1  local (fabric) access request, held until granted.
REQ-010 SHALL have port loc_we  input  1  local access is write (1) or read (0), valid with loc_req.
REQ-011 SHALL have port loc_addr  input  7  local register address, valid with loc_req.
REQ-012 SHALL have port loc_wdata  input  DATA_REGISTER_LENGTH  local write data, valid with loc_req.
REQ-013 SHALL have port loc_gnt  output  1  one-cycle grant; local access executes this cycle.
REQ-014 SHALL have port loc_rdata  output  DATA_REGISTER_LENGTH  local read result.
REQ-015 SHALL have port loc_rvalid  output  1  one-cycle strobe, loc_rdata valid, cycle after read grant.
REQ-016 SHALL have port err_addr  output  1  sticky: access to address >= NUM_REGS occurred.
REQ-017 SHALL have port err_ovf  output  1  sticky: SPI write lost to pending-buffer overflow.

Function
REQ-018 SHALL register spi_rdata every cycle as bank[spi_addr] (1-cycle latency), 0 when spi_addr >= NUM_REGS.
REQ-019 SHALL capture each spi_wr_en pulse (addr, data) into a one-entry pending buffer; SPI side is never stalled.
REQ-020 SHALL use FSM states IDLE, SPI_WR, LOC_ACC; exactly one bank write per cycle max.
REQ-021 IDLE: pending SPI and no local-priority -> SPI_WR; else loc_req -> LOC_ACC; else stay IDLE.
REQ-022 SPI_WR: write pending entry to bank, clear pending, set local-priority if loc_req high, -> IDLE.
REQ-023 LOC_ACC: assert loc_gnt one cycle, do write or read, clear local-priority, -> IDLE.
REQ-024 Local-priority flag SHALL guarantee a waiting local request is granted before a second SPI write (no starvation either side).
REQ-025 Local read: loc_rdata = bank[loc_addr] registered, loc_rvalid the following cycle; 0 for invalid address.
REQ-026 Write to address >= NUM_REGS from either port SHALL be dropped and set err_addr; invalid local read also sets err_addr.
REQ-027 spi_wr_en while pending buffer full and not being drained that cycle SHALL drop the new write, keep the old, set err_ovf.
REQ-028 spi_wr_en in the same cycle as SPI_WR drains the buffer SHALL refill it (no overflow).
REQ-029 SPI read of an address written the same cycle SHALL return old data; new data from the next cycle.
REQ-030 err_addr and err_ovf SHALL clear only on reset.
REQ-031 loc_gnt SHALL never assert while loc_req is low.

Reset
REQ-032 rst high SHALL immediately force: all bank registers 0, FSM IDLE, pending empty, local-priority 0.
REQ-033 rst high SHALL force spi_rdata=0, loc_rdata=0, loc_gnt=0, loc_rvalid=0, err_addr=0, err_ovf=0.
REQ-034 Reset mid-access SHALL abort it; the in-flight write is not committed, no grant or rvalid issued.

Structure
REQ-035 Shared package spi_regs_pkg SHALL hold address width (7), NUM_REGS default and FSM state encoding.
REQ-036 Bank storage and read mux SHALL be sub-module spi_reg_bank (one write port, two registered read ports).

Verification
REQ-037 Reset, spi_addr=3 -> spi_rdata=0 all regs; err flags 0.
REQ-038 spi_wr_en addr=5 data=0xDEADBEEF_00000001 -> bank[5] written within 2 cycles, spi_rdata updates next cycle.
REQ-039 loc_req read addr=5 continuously while SPI writes addr=5 each 4 cycles -> loc_gnt issued between consecutive SPI writes, loc_rvalid 1 cycle after gnt.
REQ-040 Two spi_wr_en pulses in consecutive cycles while FSM in LOC_ACC -> second dropped, err_ovf=1, first committed.
REQ-041 Local write addr=20 (NUM_REGS=16) -> no bank change, err_addr=1, loc_gnt still one cycle.
REQ-042 rst asserted during SPI_WR cycle -> bank stays 0, all outputs 0 asynchronously.
